// File: rtl/steer_pkg.sv
// Shared types and constants for the steering-enable controller.
//   st_t             : FSM state encoding (2'b11 is unused/illegal)
//   FAST_SIM_CYCLES  : shortened settle time used when FAST_SIM=1
package steer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        WAIT  = 2'b01,
        STEER = 2'b10
    } st_t;

    localparam int unsigned FAST_SIM_CYCLES = 64;

endpackage

// File: rtl/steer_en_ctrl_if.sv
// Load-cell sample / steering-status bundle.
//   lft_ld, rght_ld : raw left/right load-cell samples (unsigned)
//   ld_vld          : 1-cycle strobe marking a coherent new sample pair
//   en_steer        : steering enable (registered)
//   rider_off       : high while no rider is qualified (registered)
//   st              : current controller state (debug/verification)
// master drives the samples, slave is the controller.
interface steer_en_ctrl_if #(
    parameter int LD_W = 12
);
    import steer_pkg::*;

    logic [LD_W-1:0] lft_ld;
    logic [LD_W-1:0] rght_ld;
    logic            ld_vld;
    logic            en_steer;
    logic            rider_off;
    st_t             st;

    modport master (
        output lft_ld, rght_ld, ld_vld,
        input  en_steer, rider_off, st
    );

    modport slave (
        input  lft_ld, rght_ld, ld_vld,
        output en_steer, rider_off, st
    );

endinterface

// File: rtl/steer_tmr.sv
// Saturating settle timer.
//   clk, rst_n : clock, async active-low reset
//   clr        : synchronous clear (wins over en)
//   en         : count one per clock while set
//   tmr_full   : count has reached TMR_END-1 (holds there)
module steer_tmr #(
    parameter int unsigned TMR_END = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tmr_full
);

    localparam int unsigned CW = $clog2(TMR_END);
    localparam logic [CW-1:0] LAST = CW'(TMR_END - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && !tmr_full) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tmr_full = (cnt == LAST);

endmodule

// File: rtl/steer_en_ctrl.sv
// Steering-enable controller: derives rider weight / imbalance flags from raw
// load-cell samples with hysteresis, owns the settle timer and sequences
// IDLE/WAIT/STEER.
//   clk, rst_n : clock, async active-low reset
//   bus        : steer_en_ctrl_if.slave (samples in, en_steer/rider_off/st out)
//
// state | meaning
// IDLE  | no rider qualified; rider_off=1
// WAIT  | rider present, waiting for a balanced settle period
// STEER | rider settled; en_steer=1
module steer_en_ctrl
    import steer_pkg::*;
#(
    parameter int              LD_W       = 12,
    parameter logic [LD_W-1:0] MIN_RIDER  = 12'h200,
    parameter logic [LD_W-1:0] HYST       = 12'h040,
    parameter int unsigned     TMR_CYCLES = 65_000_000,
    parameter bit              FAST_SIM   = 1'b0
) (
    input  logic            clk,
    input  logic            rst_n,
    steer_en_ctrl_if.slave  bus
);

    localparam int unsigned TMR_END = FAST_SIM ? FAST_SIM_CYCLES : TMR_CYCLES;

    // Thresholds in sum width; the low threshold saturates at 0 so lt_min can
    // never fire when HYST >= MIN_RIDER.
    localparam logic [LD_W:0] GT_THR = {1'b0, MIN_RIDER} + {1'b0, HYST};
    localparam logic [LD_W:0] LT_THR = (MIN_RIDER > HYST) ?
                                       ({1'b0, MIN_RIDER} - {1'b0, HYST}) : '0;

    logic [LD_W:0]   sum_w;
    logic [LD_W-1:0] diff_w;
    logic [LD_W:0]   diff_x;

    logic gt_min, lt_min, imb_1_4, imb_15_16;
    logic tmr_full, tmr_clr, tmr_en;

    st_t  state, nxt;
    logic en_steer_q, rider_off_q;

    always_comb begin
        sum_w  = {1'b0, bus.lft_ld} + {1'b0, bus.rght_ld};
        diff_w = (bus.lft_ld >= bus.rght_ld) ? (bus.lft_ld - bus.rght_ld)
                                             : (bus.rght_ld - bus.lft_ld);
        diff_x = {1'b0, diff_w};
    end

    // Flags only move on a sample strobe; between strobes the FSM keeps
    // evaluating against the last coherent sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gt_min    <= 1'b0;
            lt_min    <= 1'b0;
            imb_1_4   <= 1'b0;
            imb_15_16 <= 1'b0;
        end else if (bus.ld_vld) begin
            gt_min    <= (sum_w > GT_THR);
            lt_min    <= (sum_w < LT_THR);
            imb_1_4   <= (diff_x > (sum_w >> 2));
            imb_15_16 <= (diff_x > (sum_w - (sum_w >> 4)));
        end
    end

    // Timer runs only in WAIT; an imbalance (without lt_min taking priority)
    // restarts the settle period.
    assign tmr_en  = (state == WAIT);
    assign tmr_clr = (state != WAIT) || (!lt_min && imb_1_4);

    steer_tmr #(
        .TMR_END (TMR_END)
    ) u_tmr (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (tmr_clr),
        .en       (tmr_en),
        .tmr_full (tmr_full)
    );

    always_comb begin
        nxt = state;
        case (state)
            IDLE: begin
                if (gt_min) nxt = WAIT;
            end
            WAIT: begin
                if (lt_min)        nxt = IDLE;
                else if (imb_1_4)  nxt = WAIT;
                else if (tmr_full) nxt = STEER;
            end
            STEER: begin
                // Leaving STEER needs sum below the low threshold, not just
                // loss of gt_min.
                if (lt_min)          nxt = IDLE;
                else if (imb_15_16)  nxt = WAIT;
            end
            default: nxt = IDLE;
        endcase
    end

    // Outputs decoded from next state so they switch on the same edge as st.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            en_steer_q  <= 1'b0;
            rider_off_q <= 1'b1;
        end else begin
            state       <= nxt;
            en_steer_q  <= (nxt == STEER);
            rider_off_q <= (nxt == IDLE);
        end
    end

    assign bus.st        = state;
    assign bus.en_steer  = en_steer_q;
    assign bus.rider_off = rider_off_q;

endmodule

// File: tb/tb_steer_en_ctrl.sv
module tb_steer_en_ctrl;
    import steer_pkg::*;

    logic clk;
    logic rst_n;

    steer_en_ctrl_if #(.LD_W(12)) bus ();

    steer_en_ctrl #(
        .LD_W       (12),
        .MIN_RIDER  (12'h200),
        .HYST       (12'h040),
        .TMR_CYCLES (1000),
        .FAST_SIM   (1'b1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    typedef struct {
        st_t   st;
        string name;
    } exp_t;

    typedef struct {
        logic [11:0] lft;
        logic [11:0] rght;
        st_t         exp_a;   // 2 clks after strobe (from IDLE)
        st_t         exp_b;   // 66 clks after strobe
        string       name;
    } vec_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    task automatic push_exp(input st_t s, input string n);
        exp_t e;
        e.st   = s;
        e.name = n;
        sb.push_back(e);
    endtask

    task automatic check_pop();
        exp_t e;
        logic en_x, off_x;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_empty: no expectation queued");
            return;
        end
        e     = sb.pop_front();
        en_x  = (e.st == STEER);
        off_x = (e.st == IDLE);
        checks++;
        if (bus.st !== e.st) begin
            errors++;
            $display("FAIL %s st: got %0d want %0d", e.name, bus.st, e.st);
        end
        checks++;
        if (bus.en_steer !== en_x) begin
            errors++;
            $display("FAIL %s en_steer: got %b want %b", e.name, bus.en_steer, en_x);
        end
        checks++;
        if (bus.rider_off !== off_x) begin
            errors++;
            $display("FAIL %s rider_off: got %b want %b", e.name, bus.rider_off, off_x);
        end
    endtask

    task automatic wait_edges(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called at a negedge; the sample is captured on the following posedge,
    // and the task returns at the negedge right after that capture edge.
    task automatic strobe(input logic [11:0] l, input logic [11:0] r);
        bus.lft_ld  = l;
        bus.rght_ld = r;
        bus.ld_vld  = 1'b1;
        @(negedge clk);
        bus.ld_vld  = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n      = 1'b0;
        bus.ld_vld = 1'b0;
        wait_edges(2);
        rst_n = 1'b1;
        wait_edges(1);
    endtask

    vec_t vec[8];

    initial begin
        vec[0] = '{12'h140, 12'h140, WAIT, STEER, "mount_bal"};
        vec[1] = '{12'h120, 12'h120, IDLE, IDLE,  "sum_eq_gt_thr"};
        vec[2] = '{12'h121, 12'h120, WAIT, STEER, "sum_gt_thr_p1"};
        vec[3] = '{12'hFFF, 12'hFFF, WAIT, STEER, "sum_max_no_ovf"};
        vec[4] = '{12'h1F0, 12'h090, WAIT, WAIT,  "imb_held"};
        vec[5] = '{12'h000, 12'h000, IDLE, IDLE,  "empty"};
        vec[6] = '{12'h050, 12'h200, WAIT, WAIT,  "imb_light"};
        vec[7] = '{12'h172, 12'h0DE, WAIT, STEER, "imb_q_boundary"};

        rst_n       = 1'b0;
        bus.lft_ld  = 12'hFFF;
        bus.rght_ld = 12'hFFF;
        bus.ld_vld  = 1'b1;

        // Reset with arbitrary inputs active
        wait_edges(3);
        push_exp(IDLE, "reset");
        check_pop();
        bus.ld_vld = 1'b0;
        rst_n      = 1'b1;
        wait_edges(1);

        // Table: single strobe from IDLE, check at +2 and +66 clks
        for (int i = 0; i < 8; i++) begin
            do_reset();
            push_exp(vec[i].exp_a, {vec[i].name, "_a"});
            push_exp(vec[i].exp_b, {vec[i].name, "_b"});
            strobe(vec[i].lft, vec[i].rght);
            wait_edges(1);
            check_pop();
            wait_edges(64);
            check_pop();
        end

        // Exact settle timing
        do_reset();
        push_exp(IDLE, "mount_cap_edge");
        push_exp(WAIT, "mount_plus2");
        push_exp(WAIT, "settle_63");
        push_exp(STEER, "settle_64");
        strobe(12'h140, 12'h140);
        check_pop();
        wait_edges(1);
        check_pop();
        wait_edges(63);
        check_pop();
        wait_edges(1);
        check_pop();

        // Imbalance mid-settle restarts the timer
        do_reset();
        strobe(12'h140, 12'h140);
        wait_edges(41);
        push_exp(WAIT, "imb_hold");
        push_exp(WAIT, "resettle_63");
        push_exp(STEER, "resettle_64");
        strobe(12'h1F0, 12'h090);
        wait_edges(30);
        check_pop();
        strobe(12'h140, 12'h140);
        wait_edges(63);
        check_pop();
        wait_edges(1);
        check_pop();

        // Hysteresis while in STEER
        push_exp(STEER, "band_0x200");
        push_exp(STEER, "lt_thr_exact");
        push_exp(STEER, "no_strobe_frozen");
        push_exp(STEER, "drop_cap_edge");
        push_exp(IDLE, "drop_idle");
        strobe(12'h100, 12'h100);
        wait_edges(5);
        check_pop();
        strobe(12'h0E0, 12'h0E0);
        wait_edges(5);
        check_pop();
        bus.lft_ld  = 12'h000;
        bus.rght_ld = 12'h000;
        wait_edges(5);
        check_pop();
        strobe(12'h0D8, 12'h0D8);
        check_pop();
        wait_edges(1);
        check_pop();

        // Step-off
        do_reset();
        push_exp(STEER, "so_steer");
        push_exp(STEER, "imb1516_boundary");
        push_exp(WAIT, "stepoff_wait");
        push_exp(WAIT, "stepoff_hold");
        push_exp(STEER, "stepoff_resettle");
        push_exp(IDLE, "lt_beats_imb");
        strobe(12'h140, 12'h140);
        wait_edges(65);
        check_pop();
        strobe(12'h26C, 12'h014);
        wait_edges(5);
        check_pop();
        strobe(12'h270, 12'h010);
        wait_edges(1);
        check_pop();
        wait_edges(70);
        check_pop();
        strobe(12'h140, 12'h140);
        wait_edges(64);
        check_pop();
        strobe(12'h1B0, 12'h000);
        wait_edges(1);
        check_pop();

        // Mid-operation reset in WAIT at cnt 30
        do_reset();
        strobe(12'h140, 12'h140);
        wait_edges(31);
        push_exp(WAIT, "pre_reset_wait");
        check_pop();
        rst_n = 1'b0;
        #1;
        push_exp(IDLE, "async_reset_wait");
        push_exp(IDLE, "post_reset_flags_clr");
        push_exp(WAIT, "post_reset_mount");
        push_exp(WAIT, "post_reset_63");
        push_exp(STEER, "post_reset_64");
        check_pop();
        @(negedge clk);
        rst_n = 1'b1;
        wait_edges(10);
        check_pop();
        strobe(12'h140, 12'h140);
        wait_edges(1);
        check_pop();
        wait_edges(63);
        check_pop();
        wait_edges(1);
        check_pop();

        // Async reset out of STEER
        rst_n = 1'b0;
        #1;
        push_exp(IDLE, "async_reset_steer");
        check_pop();
        @(negedge clk);
        rst_n = 1'b1;
        wait_edges(2);

        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover: got %0d entries want 0", sb.size());
        end
        checks++;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
